bin2bcd_seq: RTL

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that sits directly downstream of the 4x4 array multiplier. It takes the 8-bit product and presents it as decimal digits to the existing 7-segment `converter` stages, so HEX displays show 0–225 in decimal instead of hex. It uses a start/done handshake and holds its result until the next conversion completes.

---
 rtl/lab_pkg.sv | 14 +
 rtl/bin2bcd_seq_bcd_adjust.sv | 10 +
 rtl/bin2bcd_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/lab_pkg.sv
// Shared constants for the multiplier display path: bin2bcd_seq FSM encoding
// and its default geometry (8-bit product, three decimal digits).
package lab_pkg;

  localparam int BCD_WIDTH  = 8;
  localparam int BCD_DIGITS = 3;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/bin2bcd_seq_bcd_adjust.sv
// One BCD nibble correction for double-dabble: values of 5 or more get +3
// before the shift, so the result never exceeds 4'd12.
module bcd_adjust (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Optional leading-zero blank mask enabled by defining BIN2BCD_LZB_EN.
module bin2bcd_seq
  import lab_pkg::*;
#(
  parameter int WIDTH  = BCD_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int SW = 4 * DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       sh_q, sh_d;
  logic [SW-1:0]       adj_s, shifted_s;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_new_s;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                load_s;

  // Correct every BCD nibble in the upper part; the binary tail passes through.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adjust u_adj (
      .nib_i (sh_q[WIDTH + 4*g +: 4]),
      .nib_o (adj_s[WIDTH + 4*g +: 4])
    );
  end
  assign adj_s[WIDTH-1:0] = sh_q[WIDTH-1:0];

  assign shifted_s = adj_s << 1;
  assign bcd_new_s = shifted_s[SW-1:WIDTH];
  assign load_s    = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

  // Next-state logic: FSM, iteration counter, shift register and result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SHIFT;
          sh_d    = {{(4*DIGITS){1'b0}}, bin};
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sh_d  = shifted_s;
        cnt_d = cnt_q + CNT_ONE;
        if (load_s) begin
          state_d = ST_DONE;
          bcd_d   = bcd_new_s;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      sh_q    <= {SW{1'b0}};
      bcd_q   <= {(4*DIGITS){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_new_s;

  // Digit i is blanked when it and every higher digit are zero; ones never.
  always_comb begin : c_blank
    logic hi_zero;
    hi_zero     = 1'b1;
    blank_new_s = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero        = hi_zero & (bcd_new_s[4*i +: 4] == 4'd0);
      blank_new_s[i] = hi_zero;
    end
    if (load_s) begin
      blank_d = blank_new_s;
    end else begin
      blank_d = blank_q;
    end
  end

  // Blank mask register, updated together with the digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= {DIGITS{1'b0}};
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = {DIGITS{1'b0}};
`endif

endmodule
